// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : des_pkg
//  Brief   : Shared DES widths, IP table and bit-numbering helper.
//  Rev     : 1.0  initial release
// ============================================================================
package des_pkg;

   localparam int DES_BLK_W  = 64;
   localparam int DES_HALF_W = 32;

   // Initial permutation, 1-based DES bit numbering: ip[i] = x[IP_TABLE[i]-1]
   localparam int IP_TABLE [0:DES_BLK_W-1] = '{
      58, 50, 42, 34, 26, 18, 10,  2,
      60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,
      64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,
      59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,
      63, 55, 47, 39, 31, 23, 15,  7
   };

   typedef struct packed {
      logic [DES_BLK_W-1:0] blk;
      logic                 decrypt;
   } des_slot_t;

   // DES bit n (1-based) lives at vector index n-1
   function automatic int des_bit_idx(input int des_bit);
      return des_bit - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/initial_p.sv
`default_nettype none
// ============================================================================
//  Module  : initial_p
//  Brief   : Combinational DES initial permutation, mirror of the final one.
//  Rev     : 1.0  initial release
// ============================================================================
module initial_p
   import des_pkg::*;
(
   input  logic [DES_BLK_W-1:0] data_in,
   output logic [DES_BLK_W-1:0] data_out
);

   for (genvar i = 0; i < DES_BLK_W; i++) begin : g_ip
      localparam int c_src = des_bit_idx(IP_TABLE[i]);
      assign data_out[i] = data_in[c_src];
   end

endmodule
`default_nettype wire

// File: rtl/des_ip_stage.sv
`default_nettype none
// ============================================================================
//  Module  : des_ip_stage
//  Brief   : DES entry stage: IP, L0/R0 split, 2-entry skid buffer, seq tag.
//  Rev     : 1.0  initial release
// ============================================================================
module des_ip_stage
   import des_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DES_BLK_W-1:0]  in_data,
   input  logic                  in_decrypt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DES_HALF_W-1:0] out_l,
   output logic [DES_HALF_W-1:0] out_r,
   output logic                  out_decrypt,
   output logic [TAG_W-1:0]      out_tag
);

   // State is simply {s_valid, m_valid}; 2'b10 is unreachable
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b11;

   logic [DES_BLK_W-1:0] w_ip;
   des_slot_t            w_new;
   des_slot_t            r_m;
   des_slot_t            r_s;
   logic                 r_m_valid;
   logic                 r_s_valid;
   logic [TAG_W-1:0]     r_m_tag;
   logic [TAG_W-1:0]     r_s_tag;
   logic [TAG_W-1:0]     r_seq;
   logic [1:0]           w_state;
   logic                 w_accept;

   initial_p u_ip (
      .data_in  (in_data),
      .data_out (w_ip)
   );

   assign w_new    = '{blk: w_ip, decrypt: in_decrypt};
   assign in_ready = rst_n & ~r_s_valid;
   assign w_accept = in_valid & in_ready;
   assign w_state  = {r_s_valid, r_m_valid};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_m       <= '0;
         r_s       <= '0;
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
         r_m_tag   <= '0;
         r_s_tag   <= '0;
         r_seq     <= '0;
      end else begin
         if (w_accept) begin
            r_seq <= r_seq + TAG_W'(1);
         end
         case (w_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_m       <= w_new;
                  r_m_tag   <= r_seq;
                  r_m_valid <= 1'b1;
               end
            end
            ST_ONE: begin
               if (w_accept && out_ready) begin
                  r_m     <= w_new;
                  r_m_tag <= r_seq;
               end else if (w_accept) begin
                  // Downstream stalled: park the new block so M stays stable
                  r_s       <= w_new;
                  r_s_tag   <= r_seq;
                  r_s_valid <= 1'b1;
               end else if (out_ready) begin
                  r_m_valid <= 1'b0;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  r_m       <= r_s;
                  r_m_tag   <= r_s_tag;
                  r_s_valid <= 1'b0;
               end
            end
            default: begin
               r_m_valid <= 1'b0;
               r_s_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid   = r_m_valid;
   assign out_l       = r_m.blk[DES_HALF_W-1:0];
   assign out_r       = r_m.blk[DES_BLK_W-1:DES_HALF_W];
   assign out_decrypt = r_m.decrypt;
   assign out_tag     = r_m_tag;

endmodule
`default_nettype wire

// File: tb/tb_des_ip_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_des_ip_stage
//  Brief   : Self-checking bench for des_ip_stage with a queue scoreboard.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_des_ip_stage;

   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [63:0]       in_data = '0;
   logic              in_decrypt = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_l;
   logic [31:0]       out_r;
   logic              out_decrypt;
   logic [TAG_W-1:0]  out_tag;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   des_ip_stage #(.TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_decrypt  (in_decrypt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_l       (out_l),
      .out_r       (out_r),
      .out_decrypt (out_decrypt),
      .out_tag     (out_tag)
   );

   int ip_tbl [0:63] = '{
      58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7};

   int fp_tbl [0:63] = '{
      40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25};

   function automatic logic [63:0] ip_model(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[i] = x[ip_tbl[i]-1];
      return y;
   endfunction

   function automatic logic [63:0] fp_model(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[i] = x[fp_tbl[i]-1];
      return y;
   endfunction

   typedef struct packed {
      logic [31:0]      l;
      logic [31:0]      r;
      logic             dec;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             sb[$];
   logic [TAG_W-1:0] m_seq = '0;
   logic             prev_hold = 1'b0;
   exp_t             prev_out;

   // Scoreboard monitor: samples on the falling edge, mid-cycle
   always @(negedge clk) begin
      exp_t e;
      logic [63:0] p;
      if (!rst_n) begin
         sb.delete();
         m_seq     = '0;
         prev_hold = 1'b0;
      end else begin
         n_vec++;
         if (in_ready !== (sb.size() < 2)) begin
            n_err++;
            $display("FAIL mon_in_ready: got %b expected %b", in_ready, (sb.size() < 2));
         end
         n_vec++;
         if (out_valid !== (sb.size() > 0)) begin
            n_err++;
            $display("FAIL mon_out_valid: got %b expected %b", out_valid, (sb.size() > 0));
         end
         if (prev_hold) begin
            n_vec++;
            if (out_valid !== 1'b1 || {out_l, out_r, out_decrypt, out_tag} !== prev_out) begin
               n_err++;
               $display("FAIL mon_stable: got v=%b %h expected v=1 %h", out_valid,
                        {out_l, out_r, out_decrypt, out_tag}, prev_out);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL mon_extra_output: got tag %0d expected no output", out_tag);
            end else begin
               e = sb.pop_front();
               if ({out_l, out_r, out_decrypt, out_tag} !== e) begin
                  n_err++;
                  $display("FAIL mon_data: got l=%h r=%h d=%b t=%0d expected l=%h r=%h d=%b t=%0d",
                           out_l, out_r, out_decrypt, out_tag, e.l, e.r, e.dec, e.tag);
               end
            end
         end
         if (in_valid && in_ready === 1'b1) begin
            p = ip_model(in_data);
            sb.push_back('{l: p[31:0], r: p[63:32], dec: in_decrypt, tag: m_seq});
            m_seq = m_seq + 1'b1;
         end
         prev_hold = (out_valid === 1'b1) && !out_ready;
         prev_out  = '{l: out_l, r: out_r, dec: out_decrypt, tag: out_tag};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      tick();
      tick();
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_l, out_r, out_decrypt, out_tag} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b l=%h r=%h d=%b t=%0d expected all zero",
                  out_valid, out_l, out_r, out_decrypt, out_tag);
      end
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: got %b expected 1", in_ready);
      end
      tick();
   endtask

   task automatic test_single_bit();
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      in_decrypt = 1'b0;
      in_data    = 64'h1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_l !== 32'h0 || out_r !== 32'h0000_0080 || out_tag !== 4'd0) begin
         n_err++;
         $display("FAIL bit1_map: got v=%b l=%h r=%h t=%0d expected v=1 l=00000000 r=00000080 t=0",
                  out_valid, out_l, out_r, out_tag);
      end
      tick();
      in_valid = 1'b1;
      in_data  = 64'h0200_0000_0000_0000;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_l !== 32'h1 || out_r !== 32'h0 || out_tag !== 4'd1) begin
         n_err++;
         $display("FAIL bit58_map: got v=%b l=%h r=%h t=%0d expected v=1 l=00000001 r=00000000 t=1",
                  out_valid, out_l, out_r, out_tag);
      end
      tick();
   endtask

   task automatic test_round_trip();
      logic [63:0] q[$];
      logic [63:0] d;
      out_ready = 1'b1;
      for (int i = 0; i <= 1000; i++) begin
         if (i < 1000) begin
            in_valid   = 1'b1;
            in_data    = {$urandom, $urandom};
            in_decrypt = 1'($urandom_range(0, 1));
            q.push_back(in_data);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (i > 0) begin
            n_vec++;
            if (out_valid !== 1'b1 || q.size() == 0) begin
               n_err++;
               $display("FAIL round_trip_valid: got v=%b expected v=1 at block %0d", out_valid, i - 1);
            end else begin
               d = q.pop_front();
               if (fp_model({out_r, out_l}) !== d) begin
                  n_err++;
                  $display("FAIL round_trip: got %h expected %h", fp_model({out_r, out_l}), d);
               end
            end
         end
         tick();
      end
      in_valid = 1'b1;
      in_data  = '1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_l !== 32'hFFFF_FFFF || out_r !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL all_ones: got l=%h r=%h expected ffffffff ffffffff", out_l, out_r);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [63:0] d [0:2];
      logic [63:0] p;
      exp_t        got[$];
      int          acc = 0;
      do_reset();
      for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
      for (int c = 0; c < 6; c++) begin
         in_valid = (acc < 3);
         in_data  = d[acc < 3 ? acc : 2];
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         tick();
      end
      @(negedge clk);
      n_vec++;
      if (acc !== 2 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_accepts: got accepts=%0d in_ready=%b expected accepts=2 in_ready=0", acc, in_ready);
      end
      p = ip_model(d[0]);
      n_vec++;
      if (out_l !== p[31:0] || out_r !== p[63:32] || out_tag !== 4'd0) begin
         n_err++;
         $display("FAIL bp_hold: got l=%h r=%h t=%0d expected l=%h r=%h t=0", out_l, out_r, out_tag,
                  p[31:0], p[63:32]);
      end
      tick();
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_valid = (acc < 3);
         in_data  = d[acc < 3 ? acc : 2];
         @(negedge clk);
         if (out_valid && out_ready) got.push_back('{l: out_l, r: out_r, dec: out_decrypt, tag: out_tag});
         if (in_valid && in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      n_vec++;
      if (got.size() != 3) begin
         n_err++;
         $display("FAIL bp_count: got %0d outputs expected 3", got.size());
      end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         p = ip_model(d[i]);
         n_vec++;
         if (got[i].tag !== 4'(i) || got[i].l !== p[31:0] || got[i].r !== p[63:32]) begin
            n_err++;
            $display("FAIL bp_order: got t=%0d l=%h expected t=%0d l=%h", got[i].tag, got[i].l, i, p[31:0]);
         end
      end
   endtask

   task automatic test_streaming();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i <= 20; i++) begin
         if (i < 20) begin
            in_valid   = 1'b1;
            in_data    = {$urandom, $urandom};
            in_decrypt = (i % 3 == 0);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (i > 0) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_tag !== 4'((i - 1) % 16) || out_decrypt !== ((i - 1) % 3 == 0)) begin
               n_err++;
               $display("FAIL stream_%0d: got v=%b t=%0d d=%b expected v=1 t=%0d d=%b", i - 1, out_valid,
                        out_tag, out_decrypt, (i - 1) % 16, ((i - 1) % 3 == 0));
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = {$urandom, $urandom};
      tick();
      in_data = {$urandom, $urandom};
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL mid_full: got in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
      end
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL mid_rst_ready: got %b expected 0", in_ready);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || out_l !== 32'h0 || out_r !== 32'h0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_after: got v=%b l=%h r=%h rdy=%b expected v=0 l=0 r=0 rdy=1",
                  out_valid, out_l, out_r, in_ready);
      end
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = {$urandom, $urandom};
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_tag !== 4'd0) begin
         n_err++;
         $display("FAIL mid_tag: got v=%b t=%0d expected v=1 t=0", out_valid, out_tag);
      end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 5000; c++) begin
         in_valid   = 1'($urandom_range(0, 1));
         in_data    = {$urandom, $urandom};
         in_decrypt = 1'($urandom_range(0, 1));
         out_ready  = ($urandom_range(0, 2) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL random_drain: got %0d pending expected 0", sb.size());
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_bit();
      test_round_trip();
      test_backpressure();
      test_streaming();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
